// File: rtl/lv1_lv2_arb_pkg.sv
// Shared types and constants for the lv1<->lv2 bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lv1_lv2_arb_pkg;

  localparam int NUM_CORES_LV1 = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PROC       = 2'd1,
    PROC_SNOOP = 2'd2,
    TURN       = 2'd3
  } arb_state_t;

endpackage

// File: rtl/lv1_lv2_bus_arbiter_rr_picker.sv
// Round-robin picker: first eligible request at or after ptr_i, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the parent decides whether to take the winner.
module rr_picker #(
  parameter int NUM_CORES   = 4,
  parameter int CORE_ID_WID = 2
) (
  input  logic [NUM_CORES-1:0]   req_i,
  input  logic [CORE_ID_WID-1:0] ptr_i,
  input  logic [NUM_CORES-1:0]   mask_i,
  output logic [NUM_CORES-1:0]   gnt_o,
  output logic                   vld_o,
  output logic [CORE_ID_WID-1:0] idx_o
);

  logic [NUM_CORES-1:0]   eligible;
  logic [CORE_ID_WID-1:0] cand;

  assign eligible = req_i & mask_i;

  // Scan from the farthest offset down to the pointer so the closest hit wins last.
  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      cand = CORE_ID_WID'((int'(ptr_i) + i) % NUM_CORES);
      if (eligible[cand]) begin
        vld_o       = 1'b1;
        idx_o       = cand;
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lv1_lv2_bus_arbiter.sv
// Grants one processor owner of the lv1<->lv2 bus plus one nested snoop responder, both round-robin.
// Latency: request sampled in cycle M gives a registered grant in M+1; one idle turnaround between owners.
// Backpressure: requesters simply hold their req until granted; owner release forces snoop release.
module lv1_lv2_bus_arbiter
  import lv1_lv2_arb_pkg::*;
#(
  parameter int NUM_CORES   = NUM_CORES_LV1,
  parameter int CORE_ID_WID = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CORES-1:0]   bus_lv1_lv2_req_proc,
  input  logic [NUM_CORES-1:0]   bus_lv1_lv2_req_snoop,
  output logic [NUM_CORES-1:0]   bus_lv1_lv2_gnt_proc,
  output logic [NUM_CORES-1:0]   bus_lv1_lv2_gnt_snoop,
  output logic [CORE_ID_WID-1:0] proc_owner_id,
  output logic                   bus_busy
);

  localparam logic [CORE_ID_WID-1:0] LAST_ID = CORE_ID_WID'(NUM_CORES - 1);

  arb_state_t             state_q, state_d;
  logic [NUM_CORES-1:0]   gnt_proc_q, gnt_proc_d;
  logic [NUM_CORES-1:0]   gnt_snoop_q, gnt_snoop_d;
  logic [CORE_ID_WID-1:0] owner_id_q, owner_id_d;
  logic [CORE_ID_WID-1:0] proc_ptr_q, proc_ptr_d;
  logic [CORE_ID_WID-1:0] snoop_ptr_q, snoop_ptr_d;

  logic [NUM_CORES-1:0]   proc_win, snoop_win;
  logic                   proc_vld, snoop_vld;
  logic [CORE_ID_WID-1:0] proc_idx, snoop_idx;
  logic                   owner_req, holder_req;

  // The current owner can never be its own snoop responder.
  rr_picker #(.NUM_CORES(NUM_CORES), .CORE_ID_WID(CORE_ID_WID)) u_proc_pick (
    .req_i  (bus_lv1_lv2_req_proc),
    .ptr_i  (proc_ptr_q),
    .mask_i ({NUM_CORES{1'b1}}),
    .gnt_o  (proc_win),
    .vld_o  (proc_vld),
    .idx_o  (proc_idx)
  );

  rr_picker #(.NUM_CORES(NUM_CORES), .CORE_ID_WID(CORE_ID_WID)) u_snoop_pick (
    .req_i  (bus_lv1_lv2_req_snoop),
    .ptr_i  (snoop_ptr_q),
    .mask_i (~gnt_proc_q),
    .gnt_o  (snoop_win),
    .vld_o  (snoop_vld),
    .idx_o  (snoop_idx)
  );

  assign owner_req  = |(bus_lv1_lv2_req_proc & gnt_proc_q);
  assign holder_req = |(bus_lv1_lv2_req_snoop & gnt_snoop_q);

  // Next-state and next-grant decisions; owner release always takes precedence over snoop activity.
  always_comb begin
    state_d     = state_q;
    gnt_proc_d  = gnt_proc_q;
    gnt_snoop_d = gnt_snoop_q;
    owner_id_d  = owner_id_q;
    proc_ptr_d  = proc_ptr_q;
    snoop_ptr_d = snoop_ptr_q;
    unique case (state_q)
      IDLE, TURN: begin
        gnt_proc_d  = '0;
        gnt_snoop_d = '0;
        owner_id_d  = '0;
        state_d     = IDLE;
        if (proc_vld) begin
          gnt_proc_d = proc_win;
          owner_id_d = proc_idx;
          proc_ptr_d = (proc_idx == LAST_ID) ? '0 : proc_idx + 1'b1;
          state_d    = PROC;
        end
      end
      PROC: begin
        if (!owner_req) begin
          gnt_proc_d = '0;
          owner_id_d = '0;
          state_d    = TURN;
        end else if (snoop_vld) begin
          gnt_snoop_d = snoop_win;
          snoop_ptr_d = (snoop_idx == LAST_ID) ? '0 : snoop_idx + 1'b1;
          state_d     = PROC_SNOOP;
        end
      end
      PROC_SNOOP: begin
        if (!owner_req) begin
          gnt_proc_d  = '0;
          gnt_snoop_d = '0;
          owner_id_d  = '0;
          state_d     = TURN;
        end else if (!holder_req) begin
          gnt_snoop_d = '0;
          state_d     = PROC;
        end
      end
      default: begin
        gnt_proc_d  = '0;
        gnt_snoop_d = '0;
        owner_id_d  = '0;
        state_d     = IDLE;
      end
    endcase
  end

  // State, grant and pointer registers; reset drops grants at once with no turnaround.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_proc_q  <= '0;
      gnt_snoop_q <= '0;
      owner_id_q  <= '0;
      proc_ptr_q  <= '0;
      snoop_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_proc_q  <= gnt_proc_d;
      gnt_snoop_q <= gnt_snoop_d;
      owner_id_q  <= owner_id_d;
      proc_ptr_q  <= proc_ptr_d;
      snoop_ptr_q <= snoop_ptr_d;
    end
  end

  assign bus_lv1_lv2_gnt_proc  = gnt_proc_q;
  assign bus_lv1_lv2_gnt_snoop = gnt_snoop_q;
  assign proc_owner_id         = owner_id_q;
  assign bus_busy              = |gnt_proc_q;

endmodule

// File: tb/tb_lv1_lv2_bus_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic.
// Latency: compares every cycle on the falling edge against an owner/snooper reference model.
// Backpressure: n/a.
module tb_lv1_lv2_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_proc;
  logic [3:0] req_snoop;
  logic [3:0] gnt_proc;
  logic [3:0] gnt_snoop;
  logic [1:0] owner_id;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus, who answers snoops, and where each search starts.
  int m_owner = -1;
  int m_snoop = -1;
  int m_pp    = 0;
  int m_sp    = 0;

  always #5 clk = ~clk;

  lv1_lv2_bus_arbiter dut (
    .clk                   (clk),
    .rst                   (rst),
    .bus_lv1_lv2_req_proc  (req_proc),
    .bus_lv1_lv2_req_snoop (req_snoop),
    .bus_lv1_lv2_gnt_proc  (gnt_proc),
    .bus_lv1_lv2_gnt_snoop (gnt_snoop),
    .proc_owner_id         (owner_id),
    .bus_busy              (busy)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] req, input int ptr, input int excl);
    for (int i = 0; i < 4; i++) begin
      int c;
      c = (ptr + i) % 4;
      if (req[c[1:0]] && c != excl) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int k);
    logic [3:0] v;
    v = 4'b0000;
    if (k >= 0) v[k[1:0]] = 1'b1;
    return v;
  endfunction

  // Advance the reference model once per rising edge from the sampled requests.
  always @(posedge clk or posedge rst) begin : model
    int o, s, pp, sp, k;
    if (rst) begin
      m_owner <= -1;
      m_snoop <= -1;
      m_pp    <= 0;
      m_sp    <= 0;
    end else begin
      o = m_owner; s = m_snoop; pp = m_pp; sp = m_sp;
      if (o < 0) begin
        k = pick(req_proc, pp, -1);
        if (k >= 0) begin
          o  = k;
          pp = (k + 1) % 4;
        end
      end else if (!req_proc[o[1:0]]) begin
        o = -1;
        s = -1;
      end else if (s < 0) begin
        k = pick(req_snoop, sp, o);
        if (k >= 0) begin
          s  = k;
          sp = (k + 1) % 4;
        end
      end else if (!req_snoop[s[1:0]]) begin
        s = -1;
      end
      m_owner <= o;
      m_snoop <= s;
      m_pp    <= pp;
      m_sp    <= sp;
    end
  end

  // Compare every output with the model away from the active edge.
  always @(negedge clk) begin
    check("model_gnt_proc", gnt_proc, onehot(m_owner));
    check("model_gnt_snoop", gnt_snoop, onehot(m_snoop));
    check("model_owner_id", {2'b00, owner_id}, (m_owner >= 0) ? 4'(m_owner) : 4'd0);
    check("model_bus_busy", {3'b000, busy}, {3'b000, (m_owner >= 0)});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_idle(input string name);
    check({name, "_gnt_proc"}, gnt_proc, 4'b0000);
    check({name, "_gnt_snoop"}, gnt_snoop, 4'b0000);
    check({name, "_owner_id"}, {2'b00, owner_id}, 4'd0);
    check({name, "_busy"}, {3'b000, busy}, 4'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_idle("reset_immediate");
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] rr_seq [5];
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req_proc  = 4'b0000;
    req_snoop = 4'b0000;
    rst       = 1'b0;
    #1 rst    = 1'b1;

    // Reset then a single request from core 1.
    repeat (3) @(posedge clk);
    #2;
    check_idle("in_reset");
    rst      = 1'b0;
    req_proc = 4'b0010;
    tick();
    check("single_gnt", gnt_proc, 4'b0010);
    check("single_id", {2'b00, owner_id}, 4'd1);
    check("single_busy", {3'b000, busy}, 4'd1);
    req_proc = 4'b0000;
    do_reset();

    // Round-robin fairness with a single idle turnaround cycle per handover.
    req_proc = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        check("rr_grant", gnt_proc, rr_seq[k]);
      end
      req_proc = 4'b1111 & ~rr_seq[k];
      tick();
      check("rr_turn", gnt_proc, 4'b0000);
      req_proc = 4'b1111;
    end
    req_proc = 4'b0000;
    tick();

    // Nested snoop under owner core 2.
    req_proc = 4'b0100;
    tick();
    check("nest_owner", gnt_proc, 4'b0100);
    check("nest_owner_id", {2'b00, owner_id}, 4'd2);
    req_snoop = 4'b1001;
    tick();
    check("nest_snoop_first", gnt_snoop, 4'b0001);
    req_snoop = 4'b1000;
    tick();
    check("nest_snoop_gap", gnt_snoop, 4'b0000);
    check("nest_owner_kept", gnt_proc, 4'b0100);
    tick();
    check("nest_snoop_second", gnt_snoop, 4'b1000);
    req_snoop = 4'b0000;
    tick();
    check("nest_snoop_release", gnt_snoop, 4'b0000);

    // The owner's own snoop request is masked.
    req_proc = 4'b0000;
    tick();
    req_proc = 4'b0010;
    tick();
    check("mask_owner", gnt_proc, 4'b0010);
    req_snoop = 4'b0010;
    repeat (10) begin
      tick();
      check("mask_no_snoop", gnt_snoop, 4'b0000);
    end
    req_snoop = 4'b0000;
    req_proc  = 4'b0000;
    tick();
    tick();

    // Forced snoop release when owner core 3 drops.
    req_proc = 4'b1000;
    tick();
    check("force_owner", gnt_proc, 4'b1000);
    req_snoop = 4'b0001;
    tick();
    check("force_snoop", gnt_snoop, 4'b0001);
    req_proc = 4'b0000;
    tick();
    check("force_proc_clear", gnt_proc, 4'b0000);
    check("force_snoop_clear", gnt_snoop, 4'b0000);
    tick();
    check("force_snoop_ignored", gnt_snoop, 4'b0000);
    req_snoop = 4'b0000;

    // Asynchronous reset in the middle of a nested snoop.
    req_proc = 4'b1000;
    tick();
    req_snoop = 4'b0001;
    tick();
    check("arst_pre_snoop", gnt_snoop, 4'b0001);
    #1 rst = 1'b1;
    #1;
    check_idle("arst_mid");
    req_snoop = 4'b0000;
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    check("arst_regrant", gnt_proc, 4'b1000);
    req_snoop = 4'b0011;
    tick();
    check("arst_snoop_ptr0", gnt_snoop, 4'b0001);
    req_snoop = 4'b0000;
    req_proc  = 4'b0000;
    tick();
    req_proc = 4'b1111;
    tick();
    check("arst_proc_ptr0", gnt_proc, 4'b0001);
    req_proc = 4'b0000;
    tick();
    tick();

    // Randomized traffic with sticky-ish requests and occasional mid-cycle resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (req_proc[i]) req_proc[i] = ($urandom_range(0, 7) != 0);
        else             req_proc[i] = ($urandom_range(0, 3) == 0);
        if (req_snoop[i]) req_snoop[i] = ($urandom_range(0, 3) != 0);
        else              req_snoop[i] = ($urandom_range(0, 2) == 0);
      end
    end
    req_proc  = 4'b0000;
    req_snoop = 4'b0000;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
